// File: rtl/dfe_stage_sink_pkg.sv
// ----------------------------------------------------------------------------
// dfe_stage_sink_pkg
// Shared DFE types and the saturating-increment helper used by stage status.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dfe_stage_sink_pkg;

   localparam int c_sample_w   = 16;
   localparam int c_stat_cnt_w = 16;
   localparam int c_sat_w      = 64;

   typedef logic signed [c_sample_w-1:0] sample_t;

   typedef struct packed {
      logic [c_stat_cnt_w-1:0] ovf_cnt;
      logic [c_stat_cnt_w-1:0] unf_cnt;
      logic [c_stat_cnt_w-1:0] drop_cnt;
      logic                    sticky_ovf;
      logic                    sticky_unf;
      logic                    sticky_drop;
   } dfe_stats_t;

   // Increment that holds at the all-ones value of a 'width'-bit counter.
   function automatic logic [c_sat_w-1:0] sat_inc(input logic [c_sat_w-1:0] value,
                                                  input int unsigned         width);
      logic [c_sat_w-1:0] lim;
      lim = '1;
      if (width < c_sat_w)
         lim = (64'd1 << width) - 64'd1;
      return (value >= lim) ? value : value + 64'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dfe_stage_sink_sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
// First-word-fall-through FIFO: storage, pointers, occupancy and flush.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo_fwft
   import dfe_stage_sink_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_req,
   input  logic                     pop_req,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     not_empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                 c_ptr_w   = $clog2(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);
   localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w+1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_push;
   logic               w_pop;

   // Full is taken from the registered count, so a same-cycle pop never frees a slot.
   assign full      = (r_count == c_depth);
   assign not_empty = (r_count != '0);
   assign count     = r_count;
   assign rd_data   = r_mem[r_rd_ptr];
   assign w_push    = push_req & ~full;
   assign w_pop     = pop_req & not_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/dfe_stage_sink.sv
// ----------------------------------------------------------------------------
// dfe_stage_sink
// DFE output sink: sample FIFO with ready/valid drain plus saturating stats.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dfe_stage_sink
   import dfe_stage_sink_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_in,
   input  logic signed [DATA_WIDTH-1:0]  data_in,
   input  logic                          overflow_in,
   input  logic                          underflow_in,
   input  logic                          flush,
   input  logic                          clear_stats,
   output logic signed [DATA_WIDTH-1:0]  m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          fifo_full,
   output logic [CNT_WIDTH-1:0]          ovf_cnt,
   output logic [CNT_WIDTH-1:0]          unf_cnt,
   output logic [CNT_WIDTH-1:0]          drop_cnt,
   output logic                          sticky_ovf,
   output logic                          sticky_unf,
   output logic                          sticky_drop
);

   localparam int c_num_stats = 3;

   logic [DATA_WIDTH-1:0]             w_rd_data;
   logic [c_num_stats-1:0]            w_evt;
   logic [c_num_stats*CNT_WIDTH-1:0]  w_cnt_bus;
   logic [c_num_stats-1:0]            w_sticky_bus;

   sync_fifo_fwft #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_req  (valid_in),
      .pop_req   (m_ready),
      .flush     (flush),
      .wr_data   (data_in),
      .rd_data   (w_rd_data),
      .not_empty (m_valid),
      .full      (fifo_full),
      .count     (fill_level)
   );

   assign m_data = w_rd_data;

   // Flag events count on any valid sample, pushed or dropped.
   assign w_evt = {valid_in & fifo_full, valid_in & underflow_in, valid_in & overflow_in};

   for (genvar g = 0; g < c_num_stats; g++) begin : g_stat
      logic [CNT_WIDTH-1:0] r_cnt;
      logic                 r_sticky;

      // A clear coincident with an event leaves the event counted.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
         end else if (clear_stats) begin
            r_cnt    <= CNT_WIDTH'(w_evt[g]);
            r_sticky <= w_evt[g];
         end else if (w_evt[g]) begin
            r_cnt    <= CNT_WIDTH'(sat_inc(64'(r_cnt), CNT_WIDTH));
            r_sticky <= 1'b1;
         end
      end

      assign w_cnt_bus[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
      assign w_sticky_bus[g]                     = r_sticky;
   end

   assign ovf_cnt     = w_cnt_bus[0*CNT_WIDTH +: CNT_WIDTH];
   assign unf_cnt     = w_cnt_bus[1*CNT_WIDTH +: CNT_WIDTH];
   assign drop_cnt    = w_cnt_bus[2*CNT_WIDTH +: CNT_WIDTH];
   assign sticky_ovf  = w_sticky_bus[0];
   assign sticky_unf  = w_sticky_bus[1];
   assign sticky_drop = w_sticky_bus[2];

endmodule

`default_nettype wire

// File: doc/dfe_stage_sink.md
# dfe_stage_sink

Output-side consumer for a filter stage's sample stream (data + valid strobe + overflow/underflow flags). It captures each valid sample into a small first-word-fall-through FIFO and drains it to a downstream block over a ready/valid handshake. It also keeps saturating overflow, underflow and drop counters plus sticky flags for the control/status path. It sits between the last filter stage of the DFE chain and the output interface or capture logic.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width, signed, matches filter output
- FIFO_DEPTH, 8, entries; power of two, ≥2
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- valid_in  in  1  sample strobe from the filter stage
- data_in  in  DATA_WIDTH  signed sample
- overflow_in  in  1  sample was saturated high; qualified by valid_in
- underflow_in  in  1  sample was saturated low; qualified by valid_in
- flush  in  1  empty the FIFO; statistics untouched
- clear_stats  in  1  clear counters and sticky flags
- m_data  out  DATA_WIDTH  FIFO head sample
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  downstream accepts m_data
- fill_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- fifo_full  out  1  occupancy == FIFO_DEPTH
- ovf_cnt, unf_cnt, drop_cnt  out  CNT_WIDTH each  saturating event counters
- sticky_ovf, sticky_unf, sticky_drop  out  1 each  set on first event, held until clear_stats

## Operation
- Push condition: valid_in && !fifo_full, with fifo_full as registered at the start of the cycle. A pop in the same cycle does not free a slot for a push while full.
- Drop: valid_in && fifo_full. The sample is discarded, drop_cnt increments and sticky_drop sets.
- Pop condition: m_valid && m_ready.
- Push and pop in the same cycle when not full or empty: occupancy unchanged, both pointers advance.
- Pop while empty: ignored. m_data is don't-care when m_valid=0.
- Pointers: $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. Occupancy is tracked by a counter of $clog2(FIFO_DEPTH)+1 bits.
- Occupancy state (derived, not encoded): EMPTY (0), PARTIAL, FULL (FIFO_DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at occupancy FIFO_DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push at occupancy 1.
  - Any state→EMPTY on flush.
- Flush: pointers and occupancy are zeroed. A push or pop in the same cycle is discarded; flush has priority.
- Overflow/underflow events are counted only when valid_in=1, whether the sample is pushed or dropped.
- overflow_in and underflow_in both set in one valid cycle: both counters increment.
- Counters saturate at all-ones. No wrap.
- clear_stats with a simultaneous event: the counter loads 1 and the sticky flag sets (the event is counted after the clear). clear_stats with no event: counter loads 0 and the sticky flag clears.

## Timing
- Reset values (synchronous, rst_n low at a rising edge):
  - m_valid=0, fifo_full=0, fill_level=0, m_data=0.
  - All counters 0, all sticky flags 0.
  - Pointers 0.
- A reset asserted mid-stream discards the FIFO contents and statistics on that edge.
- Latency: a sample pushed at edge N appears on m_data with m_valid=1 after edge N, when the FIFO was empty. Otherwise samples are presented in FIFO order.
- A pop at edge N presents the next entry after edge N (zero bubble).
- fill_level, fifo_full and the counters are registered and update on the same edge as the event.
- m_data is driven from the memory at rd_ptr: combinational read of registered state, with no input-to-output combinational path.
- Throughput: one sample per clock, sustained, while m_ready=1.

## Structure
- The shared DFE package holds:
  - the sample type (signed DATA_WIDTH)
  - a stats record type {ovf_cnt, unf_cnt, drop_cnt, sticky flags}
  - a saturating-increment function, reused by the other stages' status logic
- One natural sub-module, `sync_fifo_fwft`: storage, pointers, occupancy, flush.
- The top level holds the drop, statistics and clear logic.

## Test plan
- Reset, then 3 valid samples 0x0001, 0x7FFF, 0x8000 with m_ready=1 → m_data shows each one cycle after its push, in order; fill_level never exceeds 1.
- m_ready=0, 10 consecutive valids (FIFO_DEPTH=8) → fifo_full=1 after the 8th push, drop_cnt=2, sticky_drop=1. Then m_ready=1 → the 8 first samples drain in order, then m_valid=0.
- FIFO full, valid_in and pop in the same cycle → the sample is dropped (drop_cnt+1) and fill_level drops to 7.
- 3 valids with overflow_in=1, 1 with both flags set, 1 with the flags set but valid_in=0 → ovf_cnt=4, unf_cnt=1.
- Drive 2^CNT_WIDTH+5 overflow events → ovf_cnt holds 0xFFFF. clear_stats coincident with an overflow event → ovf_cnt=1, sticky_ovf=1.
- 5 entries queued, flush asserted with a simultaneous push → fill_level=0, m_valid=0, counters unchanged. Then rst_n low for one edge mid-stream → every output returns to its reset value.
